// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Holds funct3 codes, FSM states and the legal response-latency range.
package dmem_pkg;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// Purely combinational; legality is decided by the caller.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] ldata
);

  logic [31:0] rsh;

  assign rsh = rword >> {addr_lo, 3'b000};

  always_comb begin
    be       = '0;
    wdata_sh = '0;
    ldata    = '0;
    case (funct3)
      F3_B: begin
        be       = 4'b0001 << addr_lo;
        wdata_sh = {4{wdata[7:0]}};
        ldata    = {{24{rsh[7]}}, rsh[7:0]};
      end
      F3_BU: begin
        be       = 4'b0001 << addr_lo;
        wdata_sh = {4{wdata[7:0]}};
        ldata    = {24'h0, rsh[7:0]};
      end
      F3_H: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
        ldata    = {{16{rsh[15]}}, rsh[15:0]};
      end
      F3_HU: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
        ldata    = {16'h0, rsh[15:0]};
      end
      F3_W: begin
        be       = 4'b1111;
        wdata_sh = wdata;
        ldata    = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Word-organised data memory with a load/store front end.
// One request in flight; response appears a fixed LATENCY after accept.
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int LAT = (LATENCY < LAT_MIN) ? LAT_MIN :
                       (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q;
  logic        err_q;

  logic          accept;
  logic [AW-1:0] idx;
  logic          oor, mis, ill, err;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   ldata;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign idx       = req_addr[AW+1:2];
  assign oor       = |req_addr[31:AW+2];
  assign rword     = mem[idx];

  always_comb begin
    mis = 1'b0;
    ill = 1'b0;
    case (req_funct3)
      F3_H, F3_HU: mis = req_addr[0];
      F3_W:        mis = |req_addr[1:0];
      default:     ;
    endcase
    if (req_we) begin
      ill = !(req_funct3 == F3_B || req_funct3 == F3_H ||
              req_funct3 == F3_W);
    end else begin
      ill = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
            (req_funct3 == 3'b111);
    end
  end

  assign err = oor | mis | ill;

  dmem_lane_align u_align (
    .funct3   (req_funct3),
    .addr_lo  (req_addr[1:0]),
    .wdata    (req_wdata),
    .rword    (rword),
    .be       (be),
    .wdata_sh (wdata_sh),
    .ldata    (ldata)
  );

  // Memory is deliberately outside reset so committed stores survive rst.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LAT > 1) begin
            state_d = S_WAIT;
            cnt_d   = 3'(LAT - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rdata_q <= (req_we || err) ? 32'h0 : ldata;
        err_q   <= err;
      end
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu: vector table plus
// back-pressure and mid-flight reset sequences.
module tb_data_memory_lsu;

  localparam int LAT = 3;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  data_memory_lsu #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic run(input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] w,
                     output logic [31:0] rd, output logic er,
                     output int lat);
    int n;
    @(negedge clk);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = w;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    lat = rsp_valid ? n + 1 : -1;
    rd  = rsp_rdata;
    er  = rsp_err;
    @(posedge clk);
    #1;
  endtask

  vec_t        v[$];
  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n;
  logic        stray;

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;

    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 check("rst_ready", 32'(req_ready), 32'd1);

    v.push_back('{1'b1, 3'b010, 32'd4, 32'hDEADBEEF, 32'h0, 1'b0});
    v.push_back('{1'b0, 3'b010, 32'd4, 32'h0, 32'hDEADBEEF, 1'b0});
    v.push_back('{1'b1, 3'b010, 32'd8, 32'h12345678, 32'h0, 1'b0});
    v.push_back('{1'b1, 3'b000, 32'd9, 32'h000000AA, 32'h0, 1'b0});
    v.push_back('{1'b0, 3'b010, 32'd8, 32'h0, 32'h1234AA78, 1'b0});
    v.push_back('{1'b0, 3'b000, 32'd9, 32'h0, 32'hFFFFFFAA, 1'b0});
    v.push_back('{1'b0, 3'b100, 32'd9, 32'h0, 32'h000000AA, 1'b0});
    v.push_back('{1'b0, 3'b101, 32'd10, 32'h0, 32'h00001234, 1'b0});
    v.push_back('{1'b0, 3'b001, 32'd8, 32'h0, 32'hFFFFAA78, 1'b0});
    v.push_back('{1'b0, 3'b010, 32'd5, 32'h0, 32'h0, 1'b1});
    v.push_back('{1'b1, 3'b010, 32'd6, 32'hFFFFFFFF, 32'h0, 1'b1});
    v.push_back('{1'b0, 3'b010, 32'd4, 32'h0, 32'hDEADBEEF, 1'b0});
    v.push_back('{1'b0, 3'b011, 32'd4, 32'h0, 32'h0, 1'b1});
    v.push_back('{1'b0, 3'b010, 32'd1024, 32'h0, 32'h0, 1'b1});
    v.push_back('{1'b0, 3'b010, 32'd12, 32'h0, 32'h0, 1'b0});
    v.push_back('{1'b1, 3'b001, 32'd14, 32'hFFFFBEEF, 32'h0, 1'b0});
    v.push_back('{1'b0, 3'b010, 32'd12, 32'h0, 32'hBEEF0000, 1'b0});
    v.push_back('{1'b1, 3'b100, 32'd12, 32'h11111111, 32'h0, 1'b1});
    v.push_back('{1'b0, 3'b010, 32'd12, 32'h0, 32'hBEEF0000, 1'b0});
    v.push_back('{1'b0, 3'b001, 32'd13, 32'h0, 32'h0, 1'b1});
    v.push_back('{1'b1, 3'b000, 32'd1023, 32'h00000055, 32'h0, 1'b0});
    v.push_back('{1'b0, 3'b100, 32'd1023, 32'h0, 32'h00000055, 1'b0});
    v.push_back('{1'b0, 3'b010, 32'h80000000, 32'h0, 32'h0, 1'b1});

    foreach (v[i]) begin
      run(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rd, er, lat);
      check($sformatf("v%0d_rdata", i), rd, v[i].rdata);
      check($sformatf("v%0d_err", i), 32'(er), 32'(v[i].err));
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(LAT));
    end

    // back-pressure with a second request held on the input
    rsp_ready = 1'b0;
    @(negedge clk);
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'd8;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_addr = 32'd4;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("bp_valid", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_valid%0d", k), 32'(rsp_valid), 32'd1);
      check($sformatf("bp_hold_rdata%0d", k), rsp_rdata, 32'h1234AA78);
      check($sformatf("bp_hold_ready%0d", k), 32'(req_ready), 32'd0);
    end
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_after_valid", 32'(rsp_valid), 32'd0);
    check("bp_after_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp_second_acc", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check("bp_second_valid", 32'(rsp_valid), 32'd1);
    check("bp_second_rdata", rsp_rdata, 32'hDEADBEEF);
    check("bp_second_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1;

    // reset while a load is in flight
    @(negedge clk);
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'd4;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("mr_valid_in_rst", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 check("mr_valid_hold", 32'(rsp_valid), 32'd0);
    @(negedge clk) rst = 1'b0;
    #1 check("mr_ready", 32'(req_ready), 32'd1);
    stray = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1 if (rsp_valid) stray = 1'b1;
    end
    check("mr_no_stray", 32'(stray), 32'd0);
    run(1'b0, 3'b010, 32'd4, 32'h0, rd, er, lat);
    check("mr_reload", rd, 32'hDEADBEEF);
    check("mr_reload_err", 32'(er), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/data_memory_lsu.md
DATA_MEMORY_LSU -- requirements
Module: data_memory_lsu

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words, power of two, 16..4096.
REQ-002 Parameter LATENCY, default 1, cycles from request accept to response valid, range 1..4.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  RISC-V size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 req_addr  in  32  byte address, little-endian.
REQ-010 req_wdata  in  32  store data, right-aligned (byte/half in low bits).
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  consumer accepts response.
REQ-013 rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 rsp_err  out  1  request faulted (misaligned, illegal funct3, out of range).

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Accept = req_valid & req_ready at a rising edge; request fields sampled at that edge only.
REQ-017 Word index = req_addr[log2(DEPTH_WORDS)+1:2]; any set bit above that field SHALL raise rsp_err.
REQ-018 Misaligned: H/HU/SH with addr[0]=1, W/SW with addr[1:0]!=0 SHALL raise rsp_err.
REQ-019 Illegal funct3: loads 011/110/111; stores any code other than 000/001/010; SHALL raise rsp_err.
REQ-020 Errored stores SHALL NOT modify memory; errored loads return rsp_rdata=0.
REQ-021 Legal stores commit at the accept edge via byte-lane enables: SB one lane at addr[1:0], SH lanes at addr[1], SW all four.
REQ-022 Loads read memory at the accept edge; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-023 Accept -> WAIT if LATENCY>1 (counter loaded LATENCY-1), else -> RESP; WAIT -> RESP when counter reaches 0.
REQ-024 rsp_valid SHALL rise exactly LATENCY cycles after the accept edge, for loads and stores alike.
REQ-025 In RESP, rsp_valid, rsp_rdata, rsp_err SHALL be held stable until rsp_valid & rsp_ready; then -> IDLE next cycle.
REQ-026 No new request accepted while WAIT/RESP; a held req_valid is accepted on the first IDLE cycle.
REQ-027 Store followed by load to same word SHALL return the stored data (no stale read).
REQ-028 Memory array initialised to all zeros at time 0; unwritten words read 0.

Reset
REQ-029 rst asserted: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1 after release.
REQ-030 rst mid-operation SHALL drop any pending response; stores already committed SHALL persist; memory contents are not cleared by rst.

Structure
REQ-031 Package dmem_pkg SHALL hold funct3 constants, FSM state type, and the LATENCY range limits.
REQ-032 Sub-module dmem_lane_align (combinational) SHALL generate byte enables, shifted write data, and load extraction/extension.

Verification
REQ-033 SW 0xDEADBEEF @4, then LW @4 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid exactly LATENCY cycles after each accept.
REQ-034 SW 0x12345678 @8, SB 0xAA @9 -> LW @8 = 0x1234AA78, LB @9 = 0xFFFFFFAA, LBU @9 = 0x000000AA, LHU @10 = 0x00001234.
REQ-035 LW @5 -> rsp_err 1, rsp_rdata 0; SW 0xFFFFFFFF @6 -> rsp_err 1 and LW @4 unchanged; funct3 011 load -> rsp_err 1.
REQ-036 DEPTH_WORDS=256: LW @1024 -> rsp_err 1; LW @12 never written -> 0x00000000.
REQ-037 Hold rsp_ready low 3 cycles with req_valid high -> rsp_valid/rsp_rdata stable, req_ready 0, second request accepted only after handshake.
REQ-038 LATENCY=3: accept LW @4, assert rst 1 cycle later -> rsp_valid 0 during and after rst, req_ready 1 after release, LW @4 still 0xDEADBEEF.
